// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM with memory handshake,
// per-access wait timeout and sticky illegal/bus-error fault flags.
module multicycle_ctrl #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned ENABLE_ORI    = 1,
  parameter int unsigned ENABLE_BNE    = 1,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       zeroext,
  output logic       branch,
  output logic       bne,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IWB     = 4'd11,
    S_JUMP    = 4'd12,
    S_FAULT   = 4'd13
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               illegal_q;
  logic               illegal_d;
  logic               bus_err_q;
  logic               bus_err_d;
  logic               mem_rdy;
  logic               timeout_c;
  logic               wait_st;

  // Effective handshake: without handshaking every access completes at once.
  assign mem_rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  // A waiting access has used its whole budget and memory is still not ready.
  assign timeout_c = (MEM_HANDSHAKE != 0) && (TIMEOUT != 0) && !mem_ready &&
                     (cnt_q == CNT_W'(TIMEOUT));

  // States that wait on memory and are covered by the timeout.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

  // Next-state and Moore output decode.
  always_comb begin
    state_d  = state_q;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    zeroext  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        // Fetch strobes are held off while reset is asserted.
        irwrite = mem_rdy & reset_n;
        pcwrite = mem_rdy & reset_n;
        if (mem_rdy)        state_d = S_DECODE;
        else if (timeout_c) state_d = S_FAULT;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = (ENABLE_BNE != 0) ? S_BRANCH : S_FAULT;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = (ENABLE_ORI != 0) ? S_ORIEX : S_FAULT;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_rdy)        state_d = S_MEMWB;
        else if (timeout_c) state_d = S_FAULT;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_rdy)        state_d = S_FETCH;
        else if (timeout_c) state_d = S_FAULT;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = (op == OP_BEQ);
        bne     = (op == OP_BNE);
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IWB;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        zeroext = 1'b1;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Wait counter restarts on entering a wait state and on every ready.
  always_comb begin
    cnt_d = '0;
    if (wait_st && (state_d == state_q) && !mem_rdy) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sticky fault causes, recorded on the transition into FAULT.
  always_comb begin
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    if ((state_q == S_DECODE) && (state_d == S_FAULT)) illegal_d = 1'b1;
    if (wait_st && (state_d == S_FAULT))                bus_err_d = 1'b1;
  end

  // State, counter and fault flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: three configurations, directed
// instruction sequences, per-cycle expected state/controls queued by stimulus.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        il;
    logic        be;
  } exp_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04,
                         BNE = 6'h05, ADDI = 6'h08, ORI = 6'h0D, JMP = 6'h02,
                         BAD = 6'h3F;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  logic [5:0] opv [3];
  logic [2:0] mr = 3'b000;

  logic [2:0] pcwrite, irwrite, regwrite, memwrite, iord, regdst, memtoreg;
  logic [2:0] alusrca, zeroext, branch, bne, illegal, bus_err;
  logic [1:0] alusrcb [3];
  logic [1:0] pcsrc   [3];
  logic [1:0] aluop   [3];
  logic [3:0] stv     [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   samp   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .op(opv[0]), .mem_ready(mr[0]),
    .pcwrite(pcwrite[0]), .irwrite(irwrite[0]), .regwrite(regwrite[0]),
    .memwrite(memwrite[0]), .iord(iord[0]), .regdst(regdst[0]),
    .memtoreg(memtoreg[0]), .alusrca(alusrca[0]), .alusrcb(alusrcb[0]),
    .pcsrc(pcsrc[0]), .aluop(aluop[0]), .zeroext(zeroext[0]),
    .branch(branch[0]), .bne(bne[0]), .illegal(illegal[0]),
    .bus_err(bus_err[0]), .state(stv[0]));

  multicycle_ctrl #(.MEM_HANDSHAKE(1), .ENABLE_ORI(1), .ENABLE_BNE(0), .TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .op(opv[1]), .mem_ready(mr[1]),
    .pcwrite(pcwrite[1]), .irwrite(irwrite[1]), .regwrite(regwrite[1]),
    .memwrite(memwrite[1]), .iord(iord[1]), .regdst(regdst[1]),
    .memtoreg(memtoreg[1]), .alusrca(alusrca[1]), .alusrcb(alusrcb[1]),
    .pcsrc(pcsrc[1]), .aluop(aluop[1]), .zeroext(zeroext[1]),
    .branch(branch[1]), .bne(bne[1]), .illegal(illegal[1]),
    .bus_err(bus_err[1]), .state(stv[1]));

  multicycle_ctrl #(.MEM_HANDSHAKE(0), .ENABLE_ORI(0), .ENABLE_BNE(1), .TIMEOUT(2)) u_dut2 (
    .clk(clk), .reset_n(rst_n[2]), .op(opv[2]), .mem_ready(mr[2]),
    .pcwrite(pcwrite[2]), .irwrite(irwrite[2]), .regwrite(regwrite[2]),
    .memwrite(memwrite[2]), .iord(iord[2]), .regdst(regdst[2]),
    .memtoreg(memtoreg[2]), .alusrca(alusrca[2]), .alusrcb(alusrcb[2]),
    .pcsrc(pcsrc[2]), .aluop(aluop[2]), .zeroext(zeroext[2]),
    .branch(branch[2]), .bne(bne[2]), .illegal(illegal[2]),
    .bus_err(bus_err[2]), .state(stv[2]));

  // Control word expected for a state, from the documented state table.
  // Order: pcwrite irwrite regwrite memwrite iord regdst memtoreg alusrca
  //        alusrcb pcsrc aluop zeroext branch bne
  function automatic logic [16:0] spec_ctl(input logic [3:0] s, input logic mre,
                                           input logic [5:0] o, input logic r);
    logic pw, iw, rw, mw, io, rd, mtr, asa, ze, br, bn;
    logic [1:0] asb, ps, ao;
    {pw, iw, rw, mw, io, rd, mtr, asa, ze, br, bn} = '0;
    asb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      4'd0:  begin pw = mre & r; iw = mre & r; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin mtr = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; ao = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; ao = 2'b01; ps = 2'b01;
                   br = (o == BEQ); bn = (o == BNE); end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; ao = 2'b11; ze = 1'b1; end
      4'd11: rw = 1'b1;
      4'd12: begin ps = 2'b10; pw = 1'b1; end
      default: ;
    endcase
    return {pw, iw, rw, mw, io, rd, mtr, asa, asb, ps, ao, ze, br, bn};
  endfunction

  function automatic exp_t snap(input int d);
    exp_t a;
    a.st  = stv[d];
    a.ctl = {pcwrite[d], irwrite[d], regwrite[d], memwrite[d], iord[d],
             regdst[d], memtoreg[d], alusrca[d], alusrcb[d], pcsrc[d],
             aluop[d], zeroext[d], branch[d], bne[d]};
    a.il  = illegal[d];
    a.be  = bus_err[d];
    return a;
  endfunction

  task automatic check(input int d, input exp_t e);
    exp_t a;
    a = snap(d);
    checks++;
    samp++;
    if (a !== e) begin
      errors++;
      $display("FAIL dut%0d sample %0d: got st=%0d ctl=%b il=%b be=%b, expected st=%0d ctl=%b il=%b be=%b",
               d, samp, a.st, a.ctl, a.il, a.be, e.st, e.ctl, e.il, e.be);
    end
  endtask

  // Monitor: compare each DUT against its queued expectation every cycle.
  always @(negedge clk) begin
    if (q0.size() != 0) check(0, q0.pop_front());
    if (q1.size() != 0) check(1, q1.pop_front());
    if (q2.size() != 0) check(2, q2.pop_front());
  end

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic step(input int d, input logic [5:0] o, input logic m, input logic r,
                      input logic [3:0] s, input logic il, input logic be);
    exp_t e;
    logic mre;
    rst_n[d] = r;
    opv[d]   = o;
    mr[d]    = m;
    mre      = (d == 2) ? 1'b1 : m;
    e.st  = s;
    e.ctl = spec_ctl(s, mre, o, r);
    e.il  = il;
    e.be  = be;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) opv[i] = LW;
    @(posedge clk);
    #1;

    // Default configuration.
    step(0, LW, 1, 0, 0, 0, 0);
    step(0, LW, 1, 0, 0, 0, 0);
    step(0, LW, 1, 1, 0, 0, 0); step(0, LW, 1, 1, 1, 0, 0);
    step(0, LW, 1, 1, 2, 0, 0); step(0, LW, 1, 1, 3, 0, 0);
    step(0, LW, 1, 1, 4, 0, 0);
    step(0, SW, 1, 1, 0, 0, 0); step(0, SW, 1, 1, 1, 0, 0);
    step(0, SW, 1, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, SW, 0, 1, 5, 0, 0);
    step(0, SW, 1, 1, 5, 0, 0);
    step(0, RT, 1, 1, 0, 0, 0); step(0, RT, 1, 1, 1, 0, 0);
    step(0, RT, 1, 1, 6, 0, 0); step(0, RT, 1, 1, 7, 0, 0);
    step(0, BEQ, 1, 1, 0, 0, 0); step(0, BEQ, 1, 1, 1, 0, 0);
    step(0, BEQ, 1, 1, 8, 0, 0);
    step(0, BNE, 1, 1, 0, 0, 0); step(0, BNE, 1, 1, 1, 0, 0);
    step(0, BNE, 1, 1, 8, 0, 0);
    step(0, ADDI, 1, 1, 0, 0, 0); step(0, ADDI, 1, 1, 1, 0, 0);
    step(0, ADDI, 1, 1, 9, 0, 0); step(0, ADDI, 1, 1, 11, 0, 0);
    step(0, ORI, 1, 1, 0, 0, 0); step(0, ORI, 1, 1, 1, 0, 0);
    step(0, ORI, 1, 1, 10, 0, 0); step(0, ORI, 1, 1, 11, 0, 0);
    step(0, JMP, 1, 1, 0, 0, 0); step(0, JMP, 1, 1, 1, 0, 0);
    step(0, JMP, 1, 1, 12, 0, 0);
    step(0, LW, 0, 1, 0, 0, 0); step(0, LW, 0, 1, 0, 0, 0);
    step(0, LW, 1, 1, 0, 0, 0); step(0, LW, 1, 1, 1, 0, 0);
    step(0, LW, 1, 1, 2, 0, 0); step(0, LW, 0, 1, 3, 0, 0);
    step(0, LW, 1, 1, 3, 0, 0); step(0, LW, 1, 1, 4, 0, 0);
    step(0, BAD, 1, 1, 0, 0, 0); step(0, BAD, 1, 1, 1, 0, 0);
    step(0, BAD, 0, 1, 13, 1, 0); step(0, BAD, 1, 1, 13, 1, 0);
    step(0, LW, 1, 0, 0, 0, 0);
    step(0, LW, 1, 1, 0, 0, 0); step(0, LW, 1, 1, 1, 0, 0);
    step(0, LW, 1, 1, 2, 0, 0); step(0, LW, 0, 1, 3, 0, 0);
    step(0, LW, 1, 0, 0, 0, 0);
    step(0, LW, 1, 1, 0, 0, 0); step(0, LW, 1, 1, 1, 0, 0);
    step(0, LW, 1, 1, 2, 0, 0); step(0, LW, 1, 1, 3, 0, 0);
    step(0, LW, 1, 1, 4, 0, 0); step(0, LW, 1, 1, 0, 0, 0);

    // TIMEOUT=4, bne disabled.
    step(1, LW, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, LW, 0, 1, 0, 0, 0);
    step(1, LW, 0, 1, 13, 0, 1);
    step(1, LW, 1, 1, 13, 0, 1);
    step(1, BNE, 1, 0, 0, 0, 0);
    step(1, BNE, 1, 1, 0, 0, 0); step(1, BNE, 1, 1, 1, 0, 0);
    step(1, BNE, 1, 1, 13, 1, 0);
    step(1, LW, 1, 0, 0, 0, 0);
    step(1, LW, 1, 1, 0, 0, 0); step(1, LW, 1, 1, 1, 0, 0);
    step(1, LW, 1, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) step(1, LW, 0, 1, 3, 0, 0);
    step(1, LW, 1, 1, 3, 0, 0); step(1, LW, 1, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) step(1, SW, 0, 1, 0, 0, 0);
    step(1, SW, 1, 1, 0, 0, 0); step(1, SW, 1, 1, 1, 0, 0);
    step(1, SW, 1, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) step(1, SW, 0, 1, 5, 0, 0);
    step(1, SW, 0, 1, 13, 0, 1);

    // No handshake, ori disabled: mem_ready held low throughout.
    step(2, SW, 0, 0, 0, 0, 0);
    step(2, SW, 0, 1, 0, 0, 0); step(2, SW, 0, 1, 1, 0, 0);
    step(2, SW, 0, 1, 2, 0, 0); step(2, SW, 0, 1, 5, 0, 0);
    step(2, LW, 0, 1, 0, 0, 0); step(2, LW, 0, 1, 1, 0, 0);
    step(2, LW, 0, 1, 2, 0, 0); step(2, LW, 0, 1, 3, 0, 0);
    step(2, LW, 0, 1, 4, 0, 0);
    step(2, ORI, 0, 1, 0, 0, 0); step(2, ORI, 0, 1, 1, 0, 0);
    step(2, ORI, 0, 1, 13, 1, 0); step(2, ORI, 0, 1, 13, 1, 0);

    repeat (3) @(posedge clk);
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter ENABLE_ORI, default 1, meaning: 0 = opcode 001101 decodes as illegal.
REQ-003 Parameter ENABLE_BNE, default 1, meaning: 0 = opcode 000101 decodes as illegal.
REQ-004 Parameter TIMEOUT, default 255, meaning: maximum wait cycles per memory access; 0 disables the timeout; legal range 0..65535.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode from the instruction register; stable from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- pcwrite, irwrite, regwrite, memwrite  out  1 each  write enables.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- regdst  out  1  destination register select: 0 = rt, 1 = rd.
- memtoreg  out  1  register write data select: 0 = ALUOut, 1 = data register.
- alusrca  out  1  ALU operand A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU operand B: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct field, 11 = or.
- zeroext  out  1  immediate is zero-extended (ori).
- branch  out  1  branch if equal.
- bne  out  1  branch if not equal.
- illegal  out  1  sticky illegal-opcode fault.
- bus_err  out  1  sticky memory-timeout fault.
- state  out  4  current state code, for debug.

Function
REQ-006 Control is a Moore FSM: every output not listed for a state is 0, and outputs depend only on state, except the mem_ready gating in REQ-008.
REQ-007 States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BRANCH=8, ADDIEX=9, ORIEX=10, IWB=11, JUMP=12, FAULT=13; codes 14 and 15 are unused and go to FETCH on the next edge.
REQ-008 FETCH:
- Outputs: alusrcb=01, aluop=00, pcsrc=00.
- irwrite=pcwrite=mem_ready (both 1 when MEM_HANDSHAKE=0).
- Advance to DECODE on mem_ready, otherwise hold.
REQ-009 DECODE:
- Outputs: alusrcb=11, aluop=00.
- Next state by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100/000101 -> BRANCH; 001000 -> ADDIEX; 001101 -> ORIEX; 000010 -> JUMP.
- Any other op, or a disabled op, -> FAULT.
REQ-010 MEMADR: alusrca=1, alusrcb=10, aluop=00; op 100011 -> MEMRD, op 101011 -> MEMWR.
REQ-011 MEMRD: iord=1; advance to MEMWB on mem_ready, otherwise hold.
REQ-012 MEMWR: iord=1, memwrite=1 held for every cycle in the state; advance to FETCH on mem_ready.
REQ-013 MEMWB: memtoreg=1, regwrite=1; next state FETCH.
REQ-014 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next state RTYPEWB.
REQ-015 RTYPEWB: regdst=1, regwrite=1; next state FETCH.
REQ-016 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 when op=000100, bne=1 when op=000101; next state FETCH.
REQ-017 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state IWB.
REQ-018 ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1; next state IWB.
REQ-019 IWB: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
REQ-020 JUMP: pcsrc=10, pcwrite=1; next state FETCH.
REQ-021 FAULT: all write enables 0; the state holds until reset.
- illegal is set on entry from DECODE.
- bus_err is set on entry from a timeout.
REQ-022 Wait counter:
- Width is the minimum needed to hold TIMEOUT (at least 1 bit).
- Clears on entry to FETCH, MEMRD or MEMWR and on every mem_ready.
- Increments each cycle spent in those states with mem_ready=0.
REQ-023 Timeout: when TIMEOUT>0, the counter equals TIMEOUT and mem_ready=0, the next state is FAULT; a mem_ready in that same cycle takes priority and the FSM advances normally.
REQ-024 With MEM_HANDSHAKE=0 the counter never increments and bus_err never sets.
REQ-025 Cycle counts with mem_ready=1 throughout: lw 5; sw, R-type, addi, ori 4; beq, bne, j 3.

Reset
REQ-026 While reset_n=0, asynchronously:
- state=FETCH, wait counter=0, illegal=0, bus_err=0.
- All outputs take their FETCH values, with irwrite and pcwrite forced to 0.
REQ-027 Reset asserted in any state, including FAULT or mid memory wait, aborts the operation; the first rising edge after release evaluates FETCH.

Verification
REQ-028 Reset release, mem_ready=1, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-029 op=101011, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then state 0; bus_err=0.
REQ-030 TIMEOUT=4, mem_ready held 0 in FETCH -> state 13 after 5 cycles; bus_err=1; irwrite never 1.
REQ-031 ENABLE_BNE=0, op=000101 -> DECODE then FAULT; illegal=1; with ENABLE_BNE=1 -> BRANCH with bne=1, branch=0, aluop=01.
REQ-032 op=001101 -> ORIEX with aluop=11, zeroext=1, then IWB with regwrite=1, regdst=0.
REQ-033 reset_n pulsed low mid-MEMRD without a clock edge -> state=0 and illegal=bus_err=0 immediately; the next instruction completes normally.
